cdb_slot_sched: RTL
===================

Name: cdb_slot_sched

Overview:
- Parametrised common-data-bus (CDB) write-back scheduler for NUM_FU functional units, each with its own fixed execution latency.
- Reserves the single CDB slot at issue time so that no two results collide at write-back.
- Arbitrates same-cycle conflicts with a rotating round-robin priority.
- Sits between the reservation stations and the execution units, and drives the CDB owner select consumed by the write-back mux.

Parameters:
- NUM_FU, 4, number of functional units (2..16).
- LAT_W, 4, bits per latency field.
- FU_LAT, {4'd6,4'd4,4'd1,4'd1}, packed per-FU latency, FU i at bits [i*LAT_W +: LAT_W]; each value 1..MAX_LAT.
- MAX_LAT, 8, depth of the reservation window; every FU_LAT entry must be <= MAX_LAT.
- ID_W, $clog2(NUM_FU), width of the FU index.

Ports:
- clk  input  1  clock.
- rst_b  input  1  asynchronous active-low reset.
- issue_req  input  NUM_FU  per-FU issue request (instruction ready, FU free).
- issue_gnt  output  NUM_FU  per-FU grant, combinational, same cycle as request.
- cdb_vld  output  1  registered; a granted result occupies the CDB this cycle.
- cdb_fu_id  output  ID_W  registered; index of the owning FU, valid when cdb_vld=1.
- slot_busy  output  MAX_LAT  registered view of the reservation window; bit j set = CDB claimed j+1 cycles ahead.

Behaviour:
- Reset: issue_gnt=0, cdb_vld=0, cdb_fu_id=0, slot_busy=0, all owner tags=0, rr_ptr=0. The async assert clears all in-flight reservations; the external FUs are reset by the same rst_b.
- Timing contract: a grant to FU i in cycle t makes cdb_vld=1 with cdb_fu_id=i in cycle t+FU_LAT[i], exactly. No other cycle is affected.
- Window: MAX_LAT entries, each holding {busy, owner}.
  - Each posedge shifts the window one position toward the CDB.
  - Entry 0 loads the cdb_vld/cdb_fu_id registers.
  - New claims are merged into the post-shift window in the same edge.
- Grant rule:
  - FU i is granted iff issue_req[i]=1 and its target slot is not busy in the window.
  - The target slot must also not already be claimed by a higher-priority grant in the same cycle.
  - Grants may be multiple per cycle if their latencies differ.
- Priority order starts at rr_ptr and wraps modulo NUM_FU.
- rr_ptr update: if any request lost due to a same-cycle conflict with an equal-latency FU, rr_ptr <= (index of the highest-priority winner of that conflict)+1 mod NUM_FU. Otherwise rr_ptr holds. This guarantees alternation between colliding equal-latency units.
- Collision with an existing reservation: the requester is denied regardless of priority, and rr_ptr is not updated for it. The requester retries next cycle.
- Latency 1: claim targets cdb_vld directly at the next edge. Checked against window entry 0 (the slot entering the CDB next cycle).
- Latency MAX_LAT: claims the last window entry. Always free after the shift unless claimed the same cycle.
- issue_gnt is purely combinational from issue_req, the window and rr_ptr. It has no dependency on any other input. Requesters must not combinationally loop gnt into req.
- Deasserting issue_req without a grant is legal. A grant is never revoked.

Optional Feature:
- CDB_SCHED_PERF_EN.
- Defined:
  - Adds output conflict_cnt (32 bits). It increments once per cycle in which at least one issue_req bit is denied; it saturates at all-ones and resets to 0.
  - Adds output grant_cnt (32 bits). It increments by popcount(issue_gnt) per cycle and saturates.
- Undefined: ports and counters are absent; scheduling behaviour is identical.

Decomposition:
- Package cdb_sched_pkg holds:
  - the default FU_LAT constant;
  - the helper function fu_lat(i) that extracts a latency field;
  - the typedef slot_t {logic busy; logic [ID_W-1:0] owner;}.
- One sub-module, rr_conflict_arb: a combinational rotating-priority pick-first over an NUM_FU request vector given rr_ptr. It is instantiated per distinct target slot by a generate loop, or once with a masked request vector.

Test Plan:
- Reset mid-flight: grant FU3 (lat 6), assert rst_b=0 two cycles later, release → cdb_vld stays 0 for the next 8 cycles and slot_busy=0.
- Single issue: req=4'b0100 (FU2, lat 4) at cycle 10 → gnt=4'b0100 at cycle 10; cdb_vld=1, cdb_fu_id=2 at cycle 14 only.
- Equal-latency contention: FU0 and FU1 (both lat 1) request continuously for 6 cycles → grants alternate 0,1,0,1,0,1; cdb_vld=1 every cycle from cycle 1, with ids alternating.
- Cross-latency collision: grant FU3 (lat 6) at cycle 0, then FU2 (lat 4) requests at cycle 2 → FU2 denied at cycle 2 and granted at cycle 3; CDB shows FU3 at cycle 6, FU2 at cycle 7.
- Parallel grants: FU0, FU2 and FU3 request together with an empty window → all three granted in the same cycle; CDB shows FU0@+1, FU2@+4, FU3@+6.
- Perf counters (with CDB_SCHED_PERF_EN): contention scenario over 6 cycles → conflict_cnt=6, grant_cnt=6.

Source files
------------

// File: rtl/cdb_sched_pkg.sv
// Shared types, defaults and helpers for the CDB write-back slot scheduler.
package cdb_sched_pkg;

   localparam int unsigned MAX_ID_W  = 4;   // covers the 16-FU upper bound
   localparam int unsigned LAT_VEC_W = 256;

   localparam logic [15:0] DEF_FU_LAT = {4'd6, 4'd4, 4'd1, 4'd1};

   typedef struct packed {
      logic                busy;
      logic [MAX_ID_W-1:0] owner;
   } slot_t;

   function automatic int unsigned fu_lat(input logic [LAT_VEC_W-1:0] lat_vec,
                                          input int unsigned i,
                                          input int unsigned lat_w);
      return 32'(lat_vec >> (i * lat_w)) & ((32'd1 << lat_w) - 32'd1);
   endfunction

endpackage

// File: rtl/rr_conflict_arb.sv
// Rotating-priority pick-first over a request vector; flags when more than one
// requester was present so the caller can advance its pointer.
module rr_conflict_arb #(
   parameter int unsigned NUM_FU = 4,
   parameter int unsigned ID_W   = 2
) (
   input  logic [NUM_FU-1:0] req,
   input  logic [ID_W-1:0]   ptr,
   output logic [NUM_FU-1:0] gnt,
   output logic              multi
);

   logic        found;
   int unsigned pos;

   always_comb begin
      gnt   = '0;
      multi = 1'b0;
      found = 1'b0;
      pos   = 0;
      for (int unsigned k = 0; k < NUM_FU; k++) begin
         pos = 32'(ptr) + k;
         if (pos >= NUM_FU) pos = pos - NUM_FU;
         if (req[pos]) begin
            if (found) begin
               multi = 1'b1;
            end else begin
               found    = 1'b1;
               gnt[pos] = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/cdb_slot_sched.sv
// CDB write-back scheduler: reserves the bus slot at issue time per FU latency.
// Optional perf counters are enabled with the CDB_SCHED_PERF_EN macro.
module cdb_slot_sched
   import cdb_sched_pkg::*;
#(
   parameter int unsigned              NUM_FU  = 4,
   parameter int unsigned              LAT_W   = 4,
   parameter logic [NUM_FU*LAT_W-1:0]  FU_LAT  = DEF_FU_LAT,
   parameter int unsigned              MAX_LAT = 8,
   parameter int unsigned              ID_W    = $clog2(NUM_FU)
) (
   input  logic               clk,
   input  logic               rst_b,
   input  logic [NUM_FU-1:0]  issue_req,
   output logic [NUM_FU-1:0]  issue_gnt,
   output logic               cdb_vld,
   output logic [ID_W-1:0]    cdb_fu_id,
   output logic [MAX_LAT-1:0] slot_busy
`ifdef CDB_SCHED_PERF_EN
  ,output logic [31:0]        conflict_cnt,
   output logic [31:0]        grant_cnt
`endif
);

   localparam logic [LAT_VEC_W-1:0] FuLatVec = LAT_VEC_W'(FU_LAT);

   slot_t             win_q [MAX_LAT];
   slot_t             win_d [MAX_LAT];
   slot_t             cdb_q, cdb_d;
   logic [ID_W-1:0]   rr_q, rr_d;
   logic [NUM_FU-1:0] req_ok;
   logic [NUM_FU-1:0] grp_req [MAX_LAT];
   logic [NUM_FU-1:0] grp_gnt [MAX_LAT];
   logic              grp_multi [MAX_LAT];
   logic [NUM_FU-1:0] conf_req, conf_gnt;
   logic [ID_W-1:0]   conf_idx;
   logic              conf_multi;
   logic              unused_sig;

   // A requester is eligible only if its target slot is not already reserved.
   always_comb begin
      req_ok = '0;
      for (int unsigned i = 0; i < NUM_FU; i++) begin
         req_ok[i] = issue_req[i] & ~win_q[fu_lat(FuLatVec, i, LAT_W) - 1].busy;
      end
      for (int unsigned j = 0; j < MAX_LAT; j++) begin
         grp_req[j] = '0;
         for (int unsigned i = 0; i < NUM_FU; i++) begin
            if (fu_lat(FuLatVec, i, LAT_W) == j + 1) grp_req[j][i] = req_ok[i];
         end
      end
   end

   for (genvar j = 0; j < MAX_LAT; j++) begin : g_slot_arb
      rr_conflict_arb #(
         .NUM_FU (NUM_FU),
         .ID_W   (ID_W)
      ) u_arb (
         .req   (grp_req[j]),
         .ptr   (rr_q),
         .gnt   (grp_gnt[j]),
         .multi (grp_multi[j])
      );
   end

   // Among groups that had a same-latency conflict, the winner nearest rr_ptr sets the pointer.
   rr_conflict_arb #(
      .NUM_FU (NUM_FU),
      .ID_W   (ID_W)
   ) u_conf_arb (
      .req   (conf_req),
      .ptr   (rr_q),
      .gnt   (conf_gnt),
      .multi (conf_multi)
   );

   always_comb begin
      issue_gnt = '0;
      conf_req  = '0;
      for (int unsigned j = 0; j < MAX_LAT; j++) begin
         issue_gnt = issue_gnt | grp_gnt[j];
         if (grp_multi[j]) conf_req = conf_req | grp_gnt[j];
      end
      conf_idx = '0;
      for (int unsigned i = 0; i < NUM_FU; i++) begin
         if (conf_gnt[i]) conf_idx = ID_W'(i);
      end
      rr_d = rr_q;
      if (|conf_req) rr_d = (conf_idx == ID_W'(NUM_FU - 1)) ? '0 : conf_idx + 1'b1;
   end

   // Shift toward the CDB, then merge this cycle's claims into the shifted window.
   always_comb begin
      for (int unsigned j = 0; j + 1 < MAX_LAT; j++) begin
         win_d[j] = win_q[j+1];
      end
      win_d[MAX_LAT-1] = '0;
      cdb_d            = win_q[0];
      for (int unsigned i = 0; i < NUM_FU; i++) begin
         if (issue_gnt[i]) begin
            if (fu_lat(FuLatVec, i, LAT_W) == 1) begin
               cdb_d.busy  = 1'b1;
               cdb_d.owner = MAX_ID_W'(i);
            end else begin
               win_d[(fu_lat(FuLatVec, i, LAT_W) >= 2) ? fu_lat(FuLatVec, i, LAT_W) - 2 : 0] =
                  '{busy: 1'b1, owner: MAX_ID_W'(i)};
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         for (int unsigned j = 0; j < MAX_LAT; j++) win_q[j] <= '0;
         cdb_q <= '0;
         rr_q  <= '0;
      end else begin
         win_q <= win_d;
         cdb_q <= cdb_d;
         rr_q  <= rr_d;
      end
   end

   always_comb begin
      slot_busy = '0;
      for (int unsigned j = 0; j < MAX_LAT; j++) slot_busy[j] = win_q[j].busy;
   end

   assign cdb_vld    = cdb_q.busy;
   assign cdb_fu_id  = cdb_q.owner[ID_W-1:0];
   assign unused_sig = ^{conf_multi, cdb_q.owner};

`ifdef CDB_SCHED_PERF_EN
   logic [32:0] grant_sum;
   logic        any_denied;

   assign grant_sum  = {1'b0, grant_cnt} + 33'($countones(issue_gnt));
   assign any_denied = |(issue_req & ~issue_gnt);

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         conflict_cnt <= '0;
         grant_cnt    <= '0;
      end else begin
         if (any_denied && (conflict_cnt != '1)) conflict_cnt <= conflict_cnt + 32'd1;
         grant_cnt <= grant_sum[32] ? '1 : grant_sum[31:0];
      end
   end
`endif

endmodule
